// File: rtl/spc700_smp_io.sv
// SMP bus glue behind the SPC700 core: steers each bus cycle to audio RAM, the IPL
// boot ROM overlay or the $00F0-$00FF I/O page, and implements timers, ports and DSP window.
module spc700_smp_io #(
    parameter int T01_PRESCALE = 8,
    parameter int T2_PRESCALE  = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CPU_EN,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DO,
    input  logic        CPU_WE_N,
    output logic [7:0]  CPU_DI,
    input  logic        TICK_64K,
    output logic [15:0] RAM_A,
    output logic [7:0]  RAM_DO,
    output logic        RAM_WE_N,
    input  logic [7:0]  RAM_DI,
    output logic [5:0]  IPL_A,
    input  logic [7:0]  IPL_D,
    output logic [6:0]  DSP_A,
    output logic [7:0]  DSP_DO,
    output logic        DSP_WE,
    input  logic [7:0]  DSP_DI,
    input  logic [1:0]  SNES_PA,
    input  logic [7:0]  SNES_DI,
    input  logic        SNES_WR,
    output logic [7:0]  SNES_DO
);

    logic       cpu_wr;
    logic       cpu_rd;
    logic       io_sel;
    logic       ipl_sel;
    logic       io_wr;
    logic [3:0] io_reg;

    logic       ipl_en_reg;
    logic [2:0] tmr_en_reg;
    logic [7:0] dspaddr_reg;
    logic [7:0] dsp_do_reg;
    logic       dsp_we_reg;
    logic [7:0] aux_reg [2];

    logic [7:0] cpu2snes [4];
    logic [7:0] snes2cpu [4];
    logic [3:0] tmr_out [3];

    assign cpu_wr  = CPU_EN & ~CPU_WE_N;
    assign cpu_rd  = CPU_EN & CPU_WE_N;
    assign io_sel  = (CPU_A[15:4] == 12'h00F);
    assign ipl_sel = (CPU_A[15:6] == 10'h3FF) & ipl_en_reg;
    assign io_reg  = CPU_A[3:0];
    assign io_wr   = cpu_wr & io_sel;

    assign RAM_A    = CPU_A;
    assign RAM_DO   = CPU_DO;
    assign RAM_WE_N = ~cpu_wr;
    assign IPL_A    = CPU_A[5:0];
    assign DSP_A    = dspaddr_reg[6:0];
    assign DSP_DO   = dsp_do_reg;
    assign DSP_WE   = dsp_we_reg;
    assign SNES_DO  = cpu2snes[SNES_PA];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ipl_en_reg  <= 1'b1;
            tmr_en_reg  <= 3'b000;
            dspaddr_reg <= 8'h00;
            dsp_do_reg  <= 8'h00;
            dsp_we_reg  <= 1'b0;
            aux_reg[0]  <= 8'h00;
            aux_reg[1]  <= 8'h00;
        end else begin
            dsp_we_reg <= io_wr && (io_reg == 4'h3);
            if (io_wr) begin
                case (io_reg)
                    4'h1: begin
                        ipl_en_reg <= CPU_DO[7];
                        tmr_en_reg <= CPU_DO[2:0];
                    end
                    4'h2: dspaddr_reg <= CPU_DO;
                    4'h3: dsp_do_reg  <= CPU_DO;
                    4'h8: aux_reg[0]  <= CPU_DO;
                    4'h9: aux_reg[1]  <= CPU_DO;
                    default: ;
                endcase
            end
        end
    end

    // Communication port latches; a SNES write beats a same-cycle $F1 clear.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            localparam logic [3:0] PORT_ADDR = 4'(4 + gi);
            logic clr;
            assign clr = io_wr && (io_reg == 4'h1) && (gi < 2 ? CPU_DO[4] : CPU_DO[5]);

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    cpu2snes[gi] <= 8'h00;
                    snes2cpu[gi] <= 8'h00;
                end else begin
                    if (io_wr && (io_reg == PORT_ADDR))
                        cpu2snes[gi] <= CPU_DO;
                    if (SNES_WR && (SNES_PA == 2'(gi)))
                        snes2cpu[gi] <= SNES_DI;
                    else if (clr)
                        snes2cpu[gi] <= 8'h00;
                end
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < 3; gi++) begin : g_timer
            localparam int         PS       = (gi == 2) ? T2_PRESCALE : T01_PRESCALE;
            localparam logic [3:0] TGT_ADDR = 4'(10 + gi);
            localparam logic [3:0] OUT_ADDR = 4'(13 + gi);

            logic [15:0] pre_reg;
            logic [7:0]  target_reg;
            logic [7:0]  stage_reg;
            logic [7:0]  stage_next;
            logic [3:0]  out_reg;
            logic        stage_tick;
            logic        en_rise;
            logic        rd_clr;
            logic        inc;

            assign stage_tick = TICK_64K && (pre_reg == 16'(PS - 1));
            assign en_rise    = io_wr && (io_reg == 4'h1) && CPU_DO[gi] && !tmr_en_reg[gi];
            assign rd_clr     = cpu_rd && io_sel && (io_reg == OUT_ADDR);

            // Target 0 needs no special case: the 8-bit increment wraps to 0 and matches.
            always_comb begin
                stage_next = stage_reg;
                inc        = 1'b0;
                if (tmr_en_reg[gi] && stage_tick) begin
                    stage_next = stage_reg + 8'd1;
                    if (stage_next == target_reg) begin
                        stage_next = 8'h00;
                        inc        = 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    pre_reg    <= 16'h0000;
                    target_reg <= 8'h00;
                    stage_reg  <= 8'h00;
                    out_reg    <= 4'h0;
                end else begin
                    if (TICK_64K)
                        pre_reg <= stage_tick ? 16'h0000 : pre_reg + 16'd1;
                    if (io_wr && (io_reg == TGT_ADDR))
                        target_reg <= CPU_DO;
                    if (en_rise) begin
                        stage_reg <= 8'h00;
                        out_reg   <= 4'h0;
                    end else begin
                        stage_reg <= stage_next;
                        if (rd_clr)
                            out_reg <= inc ? 4'h1 : 4'h0;
                        else if (inc)
                            out_reg <= out_reg + 4'h1;
                    end
                end
            end

            assign tmr_out[gi] = out_reg;
        end
    endgenerate

    always_comb begin
        CPU_DI = RAM_DI;
        if (ipl_sel) begin
            CPU_DI = IPL_D;
        end else if (io_sel) begin
            case (io_reg)
                4'h0, 4'h1, 4'hA, 4'hB, 4'hC: CPU_DI = 8'h00;
                4'h2: CPU_DI = dspaddr_reg;
                4'h3: CPU_DI = DSP_DI;
                4'h4: CPU_DI = snes2cpu[0];
                4'h5: CPU_DI = snes2cpu[1];
                4'h6: CPU_DI = snes2cpu[2];
                4'h7: CPU_DI = snes2cpu[3];
                4'h8: CPU_DI = aux_reg[0];
                4'h9: CPU_DI = aux_reg[1];
                4'hD: CPU_DI = {4'h0, tmr_out[0]};
                4'hE: CPU_DI = {4'h0, tmr_out[1]};
                4'hF: CPU_DI = {4'h0, tmr_out[2]};
                default: CPU_DI = RAM_DI;
            endcase
        end
    end

endmodule

// File: tb/tb_spc700_smp_io.sv
// Directed bench for spc700_smp_io: expected values are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_spc700_smp_io;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CPU_EN = 1'b0;
    logic [15:0] CPU_A = 16'h0000;
    logic [7:0]  CPU_DO = 8'h00;
    logic        CPU_WE_N = 1'b1;
    logic [7:0]  CPU_DI;
    logic        TICK_64K = 1'b0;
    logic [15:0] RAM_A;
    logic [7:0]  RAM_DO;
    logic        RAM_WE_N;
    logic [7:0]  RAM_DI = 8'h5A;
    logic [5:0]  IPL_A;
    logic [7:0]  IPL_D = 8'hCD;
    logic [6:0]  DSP_A;
    logic [7:0]  DSP_DO;
    logic        DSP_WE;
    logic [7:0]  DSP_DI = 8'h00;
    logic [1:0]  SNES_PA = 2'd0;
    logic [7:0]  SNES_DI = 8'h00;
    logic        SNES_WR = 1'b0;
    logic [7:0]  SNES_DO;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    spc700_smp_io #(.T01_PRESCALE(8), .T2_PRESCALE(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .CPU_EN(CPU_EN), .CPU_A(CPU_A), .CPU_DO(CPU_DO),
        .CPU_WE_N(CPU_WE_N), .CPU_DI(CPU_DI), .TICK_64K(TICK_64K), .RAM_A(RAM_A),
        .RAM_DO(RAM_DO), .RAM_WE_N(RAM_WE_N), .RAM_DI(RAM_DI), .IPL_A(IPL_A),
        .IPL_D(IPL_D), .DSP_A(DSP_A), .DSP_DO(DSP_DO), .DSP_WE(DSP_WE), .DSP_DI(DSP_DI),
        .SNES_PA(SNES_PA), .SNES_DI(SNES_DI), .SNES_WR(SNES_WR), .SNES_DO(SNES_DO)
    );

    always #5 CLK = ~CLK;

    task automatic sb_check(input logic [7:0] obs, input string tag);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s observed %h with empty scoreboard", tag, obs);
        end else begin
            e = exp_q.pop_front();
            $display("check %s observed %h expected %h", tag, obs, e);
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic expect_now(input logic [7:0] obs, input logic [7:0] e, input string tag);
        exp_q.push_back(e);
        sb_check(obs, tag);
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] e, input string tag,
                            input logic tk = 1'b0);
        CPU_A = a; CPU_WE_N = 1'b1; CPU_EN = 1'b1; TICK_64K = tk;
        exp_q.push_back(e);
        @(negedge CLK);
        sb_check(CPU_DI, tag);
        @(posedge CLK); #1;
        CPU_EN = 1'b0; TICK_64K = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        CPU_A = a; CPU_DO = d; CPU_WE_N = 1'b0; CPU_EN = 1'b1;
        exp_q.push_back(8'h00);
        @(negedge CLK);
        sb_check({7'b0, RAM_WE_N}, "ram_we_n");
        @(posedge CLK); #1;
        CPU_EN = 1'b0; CPU_WE_N = 1'b1;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            TICK_64K = 1'b1;
            @(posedge CLK); #1;
            TICK_64K = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        // Reset state
        expect_now({7'b0, DSP_WE}, 8'h00, "rst_dsp_we");
        expect_now(SNES_DO, 8'h00, "rst_snes_do");
        cpu_read(16'h00F2, 8'h00, "rst_dspaddr");
        cpu_read(16'h00FD, 8'h00, "rst_t0_out");
        cpu_read(16'hFFC0, 8'hCD, "ipl_on");
        cpu_read(16'h00F1, 8'h00, "read_f1");

        // IPL overlay off
        cpu_write(16'h00F1, 8'h00);
        cpu_read(16'hFFC0, 8'h5A, "ipl_off");
        cpu_read(16'h1234, 8'h5A, "ram_read");

        // Timer 0, target 2: 32 pulses -> 4 stage ticks -> 2 outputs
        cpu_write(16'h00FA, 8'h02);
        cpu_write(16'h00F1, 8'h01);
        pulses(32);
        cpu_read(16'h00FD, 8'h02, "t0_out");
        cpu_read(16'h00FD, 8'h00, "t0_cleared");

        // Timer 2, target 0 (=256)
        cpu_write(16'h00FC, 8'h00);
        cpu_write(16'h00F1, 8'h04);
        pulses(256);
        cpu_read(16'h00FF, 8'h01, "t2_out_256");
        pulses(16 * 256);
        cpu_read(16'h00FF, 8'h00, "t2_wrap");

        // Read on the same edge as an increment
        cpu_write(16'h00FA, 8'h01);
        cpu_write(16'h00F1, 8'h01);
        pulses(16);
        pulses(7);
        cpu_read(16'h00FD, 8'h02, "t0_rd_same_edge", 1'b1);
        cpu_read(16'h00FD, 8'h01, "t0_after_same_edge");

        // Communication ports
        SNES_PA = 2'd1; SNES_DI = 8'hAA; SNES_WR = 1'b1;
        @(posedge CLK); #1;
        SNES_WR = 1'b0;
        cpu_read(16'h00F5, 8'hAA, "snes2cpu_1");
        cpu_write(16'h00F6, 8'h55);
        SNES_PA = 2'd2;
        #1 expect_now(SNES_DO, 8'h55, "cpu2snes_2");
        SNES_PA = 2'd0; SNES_DI = 8'h33; SNES_WR = 1'b1;
        cpu_write(16'h00F1, 8'h10);
        SNES_WR = 1'b0;
        cpu_read(16'h00F5, 8'h00, "clr_latch_1");
        cpu_read(16'h00F4, 8'h33, "snes_wins_clear");
        cpu_write(16'h00F8, 8'hE7);
        cpu_read(16'h00F8, 8'hE7, "aux_f8");

        // DSP window
        cpu_write(16'h00F2, 8'h8C);
        expect_now({1'b0, DSP_A}, 8'h0C, "dsp_a");
        cpu_read(16'h00F2, 8'h8C, "dspaddr_rd");
        DSP_DI = 8'h12;
        cpu_read(16'h00F3, 8'h12, "dsp_rd");
        cpu_write(16'h00F3, 8'h7F);
        expect_now({7'b0, DSP_WE}, 8'h01, "dsp_we_pulse");
        expect_now(DSP_DO, 8'h7F, "dsp_do");
        @(posedge CLK); #1;
        expect_now({7'b0, DSP_WE}, 8'h00, "dsp_we_end");

        // Reset mid-access aborts the DSP write
        CPU_A = 16'h00F3; CPU_DO = 8'h11; CPU_WE_N = 1'b0; CPU_EN = 1'b1; RST_N = 1'b0;
        @(posedge CLK); #1;
        CPU_EN = 1'b0; CPU_WE_N = 1'b1;
        expect_now({7'b0, DSP_WE}, 8'h00, "rst_abort_dsp_we");
        RST_N = 1'b1;
        cpu_read(16'hFFC0, 8'hCD, "rst_ipl_back");
        cpu_read(16'h00F2, 8'h00, "rst_dspaddr2");
        cpu_read(16'h00F4, 8'h00, "rst_latch0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
